// File: rtl/aesl_deadlock_monitor_param.sv
// Dataflow deadlock monitor: declares a deadlock when a blocked AXI-Stream port coexists with
// every dataflow process being stopped for PERSIST_CYCLES consecutive cycles.
module aesl_deadlock_monitor_param #(
    parameter int                           NUM_PROC       = 3,
    parameter int                           NUM_AXIS       = 1,
    parameter logic [NUM_AXIS*NUM_PROC-1:0] AXIS_OWNER     = '0,
    parameter int                           PERSIST_CYCLES = 1,
    parameter bit                           STICKY         = 1'b1,
    parameter int                           CNT_W          = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_PROC-1:0] inst_idle_sigs,
    input  logic [NUM_PROC-1:0] inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic [NUM_AXIS-1:0] axis_block_info,
    output logic [NUM_PROC-1:0] proc_stop_info,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam int                PCNT_W    = $clog2(PERSIST_CYCLES + 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERSIST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_BLOCKED = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PCNT_W-1:0]   pcnt;
    logic [PCNT_W-1:0]   pcnt_next;
    logic [NUM_PROC-1:0] proc_axis;
    logic [NUM_PROC-1:0] stop;
    logic                cond;
    logic                entering;

    // A process is stopped when idle, stalled on an internal channel, or stalled on an owned AXIS port.
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        proc_axis = '0;
        for (int p = 0; p < NUM_PROC; p++) begin
            for (int a = 0; a < NUM_AXIS; a++) begin
                proc_axis[p] = proc_axis[p] | (axis_block_sigs[a] & AXIS_OWNER[a*NUM_PROC+p]);
            end
        end
        stop = inst_idle_sigs | inst_block_sigs | proc_axis;
        cond = (|proc_axis) & (&stop);
    end

    always_comb begin
        state_next = state;
        pcnt_next  = pcnt;
        case (state)
            S_IDLE: begin
                if (cond) begin
                    if (PERSIST_CYCLES == 1) begin
                        state_next = S_BLOCKED;
                        pcnt_next  = '0;
                    end else begin
                        state_next = S_ARMED;
                        pcnt_next  = PCNT_ONE;
                    end
                end else begin
                    pcnt_next = '0;
                end
            end
            S_ARMED: begin
                if (!cond) begin
                    state_next = S_IDLE;
                    pcnt_next  = '0;
                end else if (pcnt == PCNT_LAST) begin
                    state_next = S_BLOCKED;
                    pcnt_next  = '0;
                end else begin
                    pcnt_next = pcnt + 1'b1;
                end
            end
            S_BLOCKED: begin
                if (!STICKY && !cond) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                pcnt_next  = '0;
            end
        endcase
    end

    assign entering = (state_next == S_BLOCKED) && (state != S_BLOCKED);

    // Snapshots are only loaded on entry and zeroed on exit, so they read 0 whenever block is low.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state           <= S_IDLE;
            pcnt            <= '0;
            axis_block_info <= '0;
            proc_stop_info  <= '0;
            stall_cycles    <= '0;
        end else begin
            state <= state_next;
            pcnt  <= pcnt_next;
            if (entering) begin
                axis_block_info <= axis_block_sigs;
                proc_stop_info  <= stop;
                stall_cycles    <= '0;
            end else if (state == S_BLOCKED) begin
                if (stall_cycles != CNT_MAX) begin
                    stall_cycles <= stall_cycles + 1'b1;
                end
                if (state_next != S_BLOCKED) begin
                    axis_block_info <= '0;
                    proc_stop_info  <= '0;
                end
            end
        end
    end

    assign block = (state == S_BLOCKED);

endmodule

// File: tb/tb_aesl_deadlock_monitor_param.sv
// Bench for aesl_deadlock_monitor_param: two configurations driven by directed and random stimulus,
// compared every cycle with a run-length reference model.
module tb_aesl_deadlock_monitor_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       clear;
    logic [0:0] axis_a;
    logic [1:0] axis_b;
    logic [2:0] idle;
    logic [2:0] chan;

    logic        block_a;
    logic [0:0]  ainfo_a;
    logic [2:0]  pinfo_a;
    logic [15:0] stall_a;
    logic        block_b;
    logic [1:0]  ainfo_b;
    logic [2:0]  pinfo_b;
    logic [2:0]  stall_b;

    // A: one AXIS port owned by process 1, immediate declaration, sticky.
    aesl_deadlock_monitor_param #(
        .NUM_PROC(3), .NUM_AXIS(1), .AXIS_OWNER(3'b010),
        .PERSIST_CYCLES(1), .STICKY(1'b1), .CNT_W(16)
    ) dut_a (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_a),
        .inst_idle_sigs(idle), .inst_block_sigs(chan), .clear(clear),
        .block(block_a), .axis_block_info(ainfo_a), .proc_stop_info(pinfo_a),
        .stall_cycles(stall_a)
    );

    // B: port 0 owned by process 0, port 1 owned by process 2; 4-cycle persistence, non-sticky.
    aesl_deadlock_monitor_param #(
        .NUM_PROC(3), .NUM_AXIS(2), .AXIS_OWNER(6'b100001),
        .PERSIST_CYCLES(4), .STICKY(1'b0), .CNT_W(3)
    ) dut_b (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_b),
        .inst_idle_sigs(idle), .inst_block_sigs(chan), .clear(clear),
        .block(block_b), .axis_block_info(ainfo_b), .proc_stop_info(pinfo_b),
        .stall_cycles(stall_b)
    );

    typedef struct {
        bit         blk;
        int         run;
        int         stall;
        logic [1:0] ainfo;
        logic [2:0] pinfo;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Deadlock is declared once cond has held for `persist` consecutive cycles.
    function automatic mdl_t model_step(input mdl_t m, input int persist, input bit sticky,
                                        input int smax, input bit kill, input bit c,
                                        input logic [1:0] axis_now, input logic [2:0] stop_now);
        mdl_t r = m;
        if (kill) begin
            r.blk = 1'b0; r.run = 0; r.stall = 0; r.ainfo = '0; r.pinfo = '0;
        end else if (m.blk) begin
            if (r.stall < smax) r.stall = r.stall + 1;
            if (!sticky && !c) begin
                r.blk = 1'b0; r.run = 0; r.ainfo = '0; r.pinfo = '0;
            end
        end else if (c) begin
            r.run = m.run + 1;
            if (r.run >= persist) begin
                r.blk = 1'b1; r.run = 0; r.stall = 0; r.ainfo = axis_now; r.pinfo = stop_now;
            end
        end else begin
            r.run = 0;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_block", 16'(block_a), 16'(ma.blk));
        check("a_axis_info", 16'(ainfo_a), 16'(ma.ainfo[0]));
        check("a_proc_info", 16'(pinfo_a), 16'(ma.pinfo));
        check("a_stall", stall_a, 16'(ma.stall));
        check("b_block", 16'(block_b), 16'(mb.blk));
        check("b_axis_info", 16'(ainfo_b), 16'(mb.ainfo));
        check("b_proc_info", 16'(pinfo_b), 16'(mb.pinfo));
        check("b_stall", 16'(stall_b), 16'(mb.stall));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then compare after the edge.
    task automatic cycle(input logic r, input logic c, input logic a, input logic [1:0] b,
                         input logic [2:0] i, input logic [2:0] ch);
        logic [2:0] own_a;
        logic [2:0] own_b;
        logic [2:0] stop_a;
        logic [2:0] stop_b;
        bit         kill;
        reset = r; clear = c; axis_a = a; axis_b = b; idle = i; chan = ch;
        own_a  = {1'b0, a, 1'b0};
        own_b  = {b[1], 1'b0, b[0]};
        stop_a = i | ch | own_a;
        stop_b = i | ch | own_b;
        kill   = (r === 1'b1) || (c === 1'b1);
        @(posedge clock);
        ma = model_step(ma, 1, 1'b1, 65535, kill, (|own_a) && (&stop_a), {1'b0, a}, stop_a);
        mb = model_step(mb, 4, 1'b0, 7, kill, (|own_b) && (&stop_b), b, stop_b);
        #1;
        check_all();
    endtask

    initial begin
        logic       rr;
        logic       cc;
        logic       a;
        logic [1:0] b;
        logic [2:0] i;
        logic [2:0] ch;

        ma = '{blk: 1'b0, run: 0, stall: 0, ainfo: '0, pinfo: '0};
        mb = ma;

        // Reset, with unknown data inputs on the first cycle.
        cycle(1'b1, 1'b0, 1'bx, 2'bxx, 3'bxxx, 3'bxxx);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 3'b000);

        // T1: immediate declaration with snapshot.
        cycle(1'b0, 1'b0, 1'b1, 2'b00, 3'b101, 3'b000);
        check("t1_block", 16'(block_a), 16'd1);
        check("t1_axis_info", 16'(ainfo_a), 16'd1);
        check("t1_proc_info", 16'(pinfo_a), 16'h7);

        // T3: sticky block survives a dropped condition; clear wipes everything.
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 3'b000);
        check("t3_sticky_block", 16'(block_a), 16'd1);
        check("t3_stall", stall_a, 16'd3);
        cycle(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 3'b000);
        check("t3_clear_block", 16'(block_a), 16'd0);
        check("t3_clear_stall", stall_a, 16'd0);

        // Clear coinciding with cond wins; counting restarts the next cycle.
        cycle(1'b0, 1'b1, 1'b1, 2'b00, 3'b101, 3'b000);
        check("clr_cond_block", 16'(block_a), 16'd0);
        cycle(1'b0, 1'b0, 1'b1, 2'b00, 3'b101, 3'b000);
        check("clr_cond_restart", 16'(block_a), 16'd1);
        cycle(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 3'b000);

        // T2: three qualifying cycles, a gap, then four.
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 2'b01, 3'b110, 3'b000);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 3'b110, 3'b000);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 2'b01, 3'b110, 3'b000);
        check("t2_not_yet", 16'(block_b), 16'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'b01, 3'b110, 3'b000);
        check("t2_declared", 16'(block_b), 16'd1);
        check("t2_axis_info", 16'(ainfo_b), 16'h1);

        // T4: non-sticky release; counter keeps its final value.
        for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 1'b0, 2'b01, 3'b110, 3'b000);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 3'b000);
        check("t4_release", 16'(block_b), 16'd0);
        check("t4_stall_hold", 16'(stall_b), 16'd3);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 3'b000);
        check("t4_info_zero", 16'(pinfo_b), 16'd0);

        // T5: long stall saturates the 3-bit counter.
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0, 1'b0, 2'b01, 3'b110, 3'b000);
        check("t5_block", 16'(block_b), 16'd1);
        check("t5_saturate", 16'(stall_b), 16'd7);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 3'b000);

        // T6: reset in the middle of the persistence window.
        for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 1'b0, 2'b10, 3'b111, 3'b000);
        cycle(1'b1, 1'b0, 1'b0, 2'b10, 3'b111, 3'b000);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 3'b000);
        check("t6_block", 16'(block_b), 16'd0);
        check("t6_stall", 16'(stall_b), 16'd0);
        check("t6_axis_info", 16'(ainfo_b), 16'd0);

        // Randomized traffic; inputs are often held to build long qualifying runs.
        a = 1'b0; b = 2'b00; i = 3'b000; ch = 3'b000;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = ($urandom_range(0, 9) < 7);
                b = 2'($urandom);
                for (int p = 0; p < 3; p++) begin
                    i[p]  = ($urandom_range(0, 9) < 8);
                    ch[p] = ($urandom_range(0, 9) < 3);
                end
            end
            rr = ($urandom_range(0, 99) == 0);
            cc = ($urandom_range(0, 39) == 0);
            cycle(rr, cc, a, b, i, ch);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
